overdrive_step_ctrl: RTL and testbench
======================================

Name: overdrive_step_ctrl

Overview:
- Head-positioning stage inside the controller circuit, directly downstream of the bus STEP/DIR pins.
- Samples bus step pulses and generates timed stepper-motor pulses with settle time.
- Maintains the 7-bit current-track count consumed as int_trk_count by the read/write circuit, and drives the bus track_0 output.

Parameters:
- STEP_PULSE_CYC, 2400, clk cycles step_motor is held high per step (100 us at 24 MHz).
- SETTLE_CYC, 72000, clk cycles of head settle after each motor pulse (3 ms at 24 MHz).
- MAX_TRACK, 79, highest legal track number.
- SYNC_STAGES, 2, flip-flop stages on every asynchronous input.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- drive_en  in  1  drive selected (already decoded, active-high)
- step  in  1  bus step, active-low, asynchronous
- dir_sel  in  1  bus direction, asynchronous; low = inward (+1), high = outward (-1)
- t00_sens  in  1  track-00 optical sensor, active-high, asynchronous
- step_motor  out  1  stepper pulse, active-high
- step_dir  out  1  stepper direction; 1 = inward
- int_trk_count  out  7  current track, 0..MAX_TRACK
- track_0  out  1  bus track-00 indication, active-low
- seek_busy  out  1  high while a step is in progress or pending
- step_ovf  out  1  sticky; a step was dropped

Behaviour:
- Reset values: int_trk_count=0, step_motor=0, step_dir=0, track_0=1, seek_busy=0, step_ovf=0, state IDLE, pending empty.
- step, dir_sel and t00_sens each pass through SYNC_STAGES flip-flops.
- A step event is a synchronized falling edge of step while drive_en=1. dir_sel is sampled on the same cycle as the edge.
- Edges seen while drive_en=0 are ignored entirely.
- States:
  - IDLE
  - PULSE: step_motor=1 for exactly STEP_PULSE_CYC cycles.
  - SETTLE: SETTLE_CYC cycles with step_motor=0.
  - When SETTLE ends, go to IDLE, or back to PULSE if a step is pending.
- Acceptance, evaluated in IDLE on the event cycle:
  - Inward with count<MAX_TRACK: count+1 registered on the next cycle; step_dir=1; enter PULSE on the next cycle.
  - Inward with count==MAX_TRACK: no pulse; count unchanged; stay in IDLE.
  - Outward with count>0: count-1; step_dir=0; enter PULSE.
  - Outward with count==0 and synchronized t00_sens=0 (recalibration): pulse the motor; count stays 0.
  - Outward with count==0 and t00_sens=1: ignored.
- Latency from synchronized edge to step_motor rising is 1 cycle.
- Pending buffer:
  - One-deep; holds direction.
  - A step event during PULSE or SETTLE fills the buffer if it is empty.
  - If the buffer is full, the event is dropped and step_ovf is set.
  - A pending step gets its acceptance evaluated at SETTLE exit, using the count at that time.
- seek_busy = (state != IDLE) | pending.
- track_0 = ~(t00_sens_sync & (count==0)), registered.
- step_ovf clears only on rst.
- Counters are sized to hold max(STEP_PULSE_CYC, SETTLE_CYC). They reload to 0 on every state entry. No wrap on int_trk_count: it is saturated by the acceptance rules.
- rst mid-pulse: step_motor drops asynchronously, the pending step is discarded, and all outputs take reset values.
- drive_en falling mid-operation: the current PULSE/SETTLE completes; the pending step is still serviced.

Optional Feature:
- Macro OVERDRIVE_T00_RESYNC_EN.
- Defined: in IDLE, if synchronized t00_sens=1 and count!=0, force count to 0 on the next cycle (lost-step correction). Also, an outward step accepted with count==1 and t00_sens=0 sets count to 0 normally.
- Undefined: count changes only via accepted steps; t00_sens affects only track_0 and recalibration acceptance.

Decomposition:
- Package overdrive_pkg holds:
  - TRK_W=7
  - MAX_TRACK default
  - state encoding constants for IDLE/PULSE/SETTLE
- Sub-module overdrive_sync: parameterized SYNC_STAGES synchronizer with a falling-edge strobe output. It is instantiated for step; dir_sel and t00_sens use the level output only.

Test Plan:
- Reset, drive_en=1, 3 step low pulses with dir_sel=0, each spaced more than PULSE+SETTLE:
  - step_motor pulses 3 times, each exactly STEP_PULSE_CYC cycles high.
  - int_trk_count=3; track_0=1.
- count=1, t00_sens=1, one outward step:
  - count=0; track_0=0 after sync latency plus 1 cycle.
  - A further outward step produces no pulse.
- 3 steps issued back-to-back within one PULSE:
  - 2 motor pulses occur; count +2; step_ovf=1.
  - seek_busy stays high continuously until the second SETTLE ends.
- count=79, inward step:
  - No pulse; count stays 79; seek_busy stays 0.
- drive_en=0 with 5 step edges:
  - No pulses; count unchanged.
  - Then assert rst during a PULSE: step_motor=0 immediately, count=0.
- With OVERDRIVE_T00_RESYNC_EN, count=5 in IDLE, raise t00_sens:
  - count=0 within SYNC_STAGES+1 cycles.
  - Without the macro: count stays 5.

Source files
------------

// File: rtl/overdrive_pkg.sv
//------------------------------------------------------------------------------
// Module      : overdrive_pkg
// Description : Shared widths, track limit and state encoding for the
//               overdrive head-stepping controller.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package overdrive_pkg;

    localparam int TRK_W         = 7;
    localparam int DEF_MAX_TRACK = 79;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_PULSE  = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;

endpackage

`default_nettype wire

// File: rtl/overdrive_sync.sv
//------------------------------------------------------------------------------
// Module      : overdrive_sync
// Description : Multi-stage synchronizer with a falling-edge strobe taken
//               from the synchronized level.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module overdrive_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;
    logic [STAGES:0]   w_shift;

    assign w_shift = {r_sync, async_in};
    assign level   = r_sync[STAGES-1];
    assign fall    = r_prev & ~r_sync[STAGES-1];

    // Resetting to 0 means the idle-high step line only ever rises out of
    // reset, so no spurious falling edge is produced.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= w_shift[STAGES-1:0];
            r_prev <= r_sync[STAGES-1];
        end
    end

endmodule

`default_nettype wire

// File: rtl/overdrive_step_ctrl.sv
//------------------------------------------------------------------------------
// Module      : overdrive_step_ctrl
// Description : Converts bus STEP/DIR into timed stepper pulses with settle,
//               tracks the current head position and drives TRACK_0.
//               Optional macro OVERDRIVE_T00_RESYNC_EN: clears the track count
//               when the track-00 sensor is seen while idle.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module overdrive_step_ctrl
    import overdrive_pkg::*;
#(
    parameter int STEP_PULSE_CYC = 2400,
    parameter int SETTLE_CYC     = 72000,
    parameter int MAX_TRACK      = DEF_MAX_TRACK,
    parameter int SYNC_STAGES    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             drive_en,
    input  logic             step,
    input  logic             dir_sel,
    input  logic             t00_sens,
    output logic             step_motor,
    output logic             step_dir,
    output logic [TRK_W-1:0] int_trk_count,
    output logic             track_0,
    output logic             seek_busy,
    output logic             step_ovf
);

    localparam int CNT_MAX = (STEP_PULSE_CYC > SETTLE_CYC) ? STEP_PULSE_CYC : SETTLE_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [TRK_W-1:0] r_count;
    logic             r_motor;
    logic             r_step_dir;
    logic             r_pend;
    logic             r_pend_dir;
    logic             r_ovf;
    logic             r_trk0;

    logic             w_step_lvl_unused;
    logic             w_step_fall;
    logic             w_dir;
    logic             w_dir_fall_unused;
    logic             w_t00;
    logic             w_t00_fall_unused;
    logic             w_event;
    logic             w_cand_out;
    logic             w_acc;
    logic [TRK_W-1:0] w_acc_cnt;
    logic             w_pulse_end;
    logic             w_settle_end;

    overdrive_sync #(.STAGES(SYNC_STAGES)) u_sync_step (
        .clk(clk), .rst(rst), .async_in(step),
        .level(w_step_lvl_unused), .fall(w_step_fall)
    );
    overdrive_sync #(.STAGES(SYNC_STAGES)) u_sync_dir (
        .clk(clk), .rst(rst), .async_in(dir_sel),
        .level(w_dir), .fall(w_dir_fall_unused)
    );
    overdrive_sync #(.STAGES(SYNC_STAGES)) u_sync_t00 (
        .clk(clk), .rst(rst), .async_in(t00_sens),
        .level(w_t00), .fall(w_t00_fall_unused)
    );

    assign w_event      = w_step_fall & drive_en;
    assign w_pulse_end  = (r_cnt == CNT_W'(STEP_PULSE_CYC - 1));
    assign w_settle_end = (r_cnt == CNT_W'(SETTLE_CYC - 1));

    // At settle exit a buffered step takes precedence over a same-cycle event.
    assign w_cand_out = (r_state == ST_SETTLE && r_pend) ? r_pend_dir : w_dir;

    always_comb begin
        w_acc     = 1'b0;
        w_acc_cnt = r_count;
        if (!w_cand_out) begin
            if (r_count < TRK_W'(MAX_TRACK)) begin
                w_acc     = 1'b1;
                w_acc_cnt = r_count + 1'b1;
            end
        end else if (r_count != '0) begin
            w_acc     = 1'b1;
            w_acc_cnt = r_count - 1'b1;
        end else if (!w_t00) begin
            w_acc = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_count    <= '0;
            r_motor    <= 1'b0;
            r_step_dir <= 1'b0;
            r_pend     <= 1'b0;
            r_pend_dir <= 1'b0;
            r_ovf      <= 1'b0;
            r_trk0     <= 1'b1;
        end else begin
            r_trk0 <= ~(w_t00 & (r_count == '0));
            case (r_state)
                ST_IDLE: begin
                    if (w_event) begin
                        if (w_acc) begin
                            r_state    <= ST_PULSE;
                            r_motor    <= 1'b1;
                            r_cnt      <= '0;
                            r_count    <= w_acc_cnt;
                            r_step_dir <= ~w_cand_out;
                        end
                    end
`ifdef OVERDRIVE_T00_RESYNC_EN
                    else if (w_t00 && (r_count != '0)) begin
                        r_count <= '0;
                    end
`endif
                end
                ST_PULSE: begin
                    if (w_event) begin
                        if (r_pend) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_pend     <= 1'b1;
                            r_pend_dir <= w_dir;
                        end
                    end
                    if (w_pulse_end) begin
                        r_state <= ST_SETTLE;
                        r_motor <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (w_settle_end) begin
                        r_pend <= 1'b0;
                        r_cnt  <= '0;
                        if (r_pend && w_event) begin
                            r_ovf <= 1'b1;
                        end
                        if ((r_pend || w_event) && w_acc) begin
                            r_state    <= ST_PULSE;
                            r_motor    <= 1'b1;
                            r_count    <= w_acc_cnt;
                            r_step_dir <= ~w_cand_out;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        if (w_event) begin
                            if (r_pend) begin
                                r_ovf <= 1'b1;
                            end else begin
                                r_pend     <= 1'b1;
                                r_pend_dir <= w_dir;
                            end
                        end
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_motor <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign step_motor    = r_motor;
    assign step_dir      = r_step_dir;
    assign int_trk_count = r_count;
    assign track_0       = r_trk0;
    assign seek_busy     = (r_state != ST_IDLE) | r_pend;
    assign step_ovf      = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_overdrive_step_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_overdrive_step_ctrl
// Description : Randomized bench for overdrive_step_ctrl against a
//               busy-time/queue reference model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_overdrive_step_ctrl;

    localparam int P    = 6;
    localparam int S    = 9;
    localparam int MAXT = 79;
    localparam int NS   = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       drive_en = 1'b0;
    logic       step = 1'b1;
    logic       dir_sel = 1'b0;
    logic       t00_sens = 1'b0;
    logic       step_motor;
    logic       step_dir;
    logic [6:0] int_trk_count;
    logic       track_0;
    logic       seek_busy;
    logic       step_ovf;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: m_busy counts remaining busy cycles (motor phase is the
    // top P of them); one-entry pending buffer holds a direction.
    int  m_count, m_busy;
    bit  m_pend, m_pend_out, m_dir, m_ovf, m_trk0;
    bit  h_step [NS+1];
    bit  h_dir  [NS+1];
    bit  h_t00  [NS+1];
    bit  rst_req = 1'b1;
    bit  en_lvl = 1'b0;
    bit  t00_lvl = 1'b0;

    always #5 clk = ~clk;

    overdrive_step_ctrl #(
        .STEP_PULSE_CYC(P), .SETTLE_CYC(S), .MAX_TRACK(MAXT), .SYNC_STAGES(NS)
    ) dut (
        .clk(clk), .rst(rst), .drive_en(drive_en), .step(step),
        .dir_sel(dir_sel), .t00_sens(t00_sens), .step_motor(step_motor),
        .step_dir(step_dir), .int_trk_count(int_trk_count), .track_0(track_0),
        .seek_busy(seek_busy), .step_ovf(step_ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_count = 0; m_busy = 0; m_pend = 0; m_pend_out = 0;
        m_dir = 0; m_ovf = 0; m_trk0 = 1;
        for (int i = 0; i <= NS; i++) begin
            h_step[i] = 0; h_dir[i] = 0; h_t00[i] = 0;
        end
    endtask

    task automatic try_step(input bit outward, input bit t00);
        int target;
        target = outward ? m_count - 1 : m_count + 1;
        if (target >= 0 && target <= MAXT) begin
            m_count = target; m_dir = !outward; m_busy = P + S;
        end else if (outward && !t00) begin
            m_dir = 0; m_busy = P + S;
        end
    endtask

    task automatic model_advance();
        bit ev, lvl_dir, lvl_t00, nxt_trk0;
        if (rst) begin
            model_reset();
            return;
        end
        lvl_dir  = h_dir[NS-1];
        lvl_t00  = h_t00[NS-1];
        ev       = drive_en && h_step[NS] && !h_step[NS-1];
        nxt_trk0 = !(lvl_t00 && m_count == 0);
        if (m_busy == 0) begin
            if (ev) try_step(lvl_dir, lvl_t00);
`ifdef OVERDRIVE_T00_RESYNC_EN
            else if (lvl_t00 && m_count != 0) m_count = 0;
`endif
        end else begin
            if (ev) begin
                if (m_pend) m_ovf = 1;
                else begin m_pend = 1; m_pend_out = lvl_dir; end
            end
            if (m_busy == 1) begin
                m_busy = 0;
                if (m_pend) begin
                    m_pend = 0;
                    try_step(m_pend_out, lvl_t00);
                end
            end else begin
                m_busy--;
            end
        end
        m_trk0 = nxt_trk0;
        for (int i = NS; i > 0; i--) begin
            h_step[i] = h_step[i-1]; h_dir[i] = h_dir[i-1]; h_t00[i] = h_t00[i-1];
        end
        h_step[0] = step; h_dir[0] = dir_sel; h_t00[0] = t00_sens;
    endtask

    task automatic compare_all();
        check("step_motor", step_motor, m_busy > S);
        check("step_dir", step_dir, m_dir);
        check("trk_count", int_trk_count, m_count);
        check("track_0", track_0, m_trk0);
        check("seek_busy", seek_busy, (m_busy > 0) || m_pend);
        check("step_ovf", step_ovf, m_ovf);
    endtask

    task automatic tick(input bit s, input bit d);
        @(negedge clk);
        compare_all();
        rst = rst_req; step = s; dir_sel = d; drive_en = en_lvl; t00_sens = t00_lvl;
        model_advance();
    endtask

    task automatic step_pulse(input bit outward, input int low, input int gap);
        for (int i = 0; i < low; i++) tick(1'b0, outward);
        for (int i = 0; i < gap; i++) tick(1'b1, outward);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int  exp5, lo, gp, waited;
        bit  o;
        model_reset();
        repeat (3) tick(1'b1, 1'b0);
        rst_req = 0;
        en_lvl  = 1;
        repeat (4) tick(1'b1, 1'b0);

        // three spaced inward steps
        repeat (3) step_pulse(1'b0, 2, P + S + 6);
        check("cnt_after3", int_trk_count, 3);
        check("trk0_after3", track_0, 1);

        // outward to 1, then sensor high: reach 0, further outward ignored
        repeat (2) step_pulse(1'b1, 2, P + S + 6);
        t00_lvl = 1;
        step_pulse(1'b1, 2, P + S + 6);
        check("cnt_t00", int_trk_count, 0);
        check("trk0_t00", track_0, 0);
        step_pulse(1'b1, 2, P + S + 6);
        check("no_recal", int_trk_count, 0);
        t00_lvl = 0;
        repeat (4) tick(1'b1, 1'b0);

        // burst of three steps inside one pulse
        tick(1'b0, 1'b0); tick(1'b1, 1'b0);
        tick(1'b0, 1'b0); tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        repeat (2 * (P + S) + 6) tick(1'b1, 1'b0);
        check("ovf_burst", step_ovf, 1);
        check("cnt_burst", int_trk_count, 2);

        // saturate at MAX_TRACK
        repeat (MAXT) step_pulse(1'b0, 1, P + S + 3);
        check("cnt_max", int_trk_count, MAXT);
        step_pulse(1'b0, 2, 6);
        check("busy_max", seek_busy, 0);
        check("cnt_max_hold", int_trk_count, MAXT);

        // deselected drive ignores edges
        en_lvl = 0;
        repeat (5) step_pulse(1'b1, 2, 4);
        check("cnt_desel", int_trk_count, MAXT);
        check("motor_desel", step_motor, 0);

        // async reset in the middle of a pulse
        en_lvl = 1;
        tick(1'b0, 1'b1); tick(1'b0, 1'b1);
        waited = 0;
        while (!(m_busy > S) && waited < 20) begin
            tick(1'b1, 1'b1);
            waited++;
        end
        tick(1'b1, 1'b1);
        check("rst_pre_motor", step_motor, 1);
        #2;
        rst = 1; rst_req = 1;
        #1;
        check("rst_motor", step_motor, 0);
        check("rst_cnt", int_trk_count, 0);
        check("rst_busy", seek_busy, 0);
        model_reset();
        repeat (3) tick(1'b1, 1'b0);
        rst_req = 0;
        repeat (4) tick(1'b1, 1'b0);

        // five steps in, then sensor rises while idle
        repeat (5) step_pulse(1'b0, 2, P + S + 4);
        t00_lvl = 1;
        repeat (NS + 4) tick(1'b1, 1'b0);
`ifdef OVERDRIVE_T00_RESYNC_EN
        exp5 = 0;
`else
        exp5 = 5;
`endif
        check("cnt_resync", int_trk_count, exp5);
        t00_lvl = 0;

        // randomized traffic
        for (int i = 0; i < 250; i++) begin
            o  = ($urandom_range(0, 9) < 4);
            lo = $urandom_range(1, 3);
            gp = $urandom_range(1, P + S + 4);
            en_lvl = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 4) == 0) t00_lvl = ~t00_lvl;
            step_pulse(o, lo, gp);
        end
        en_lvl = 1;
        repeat (2 * (P + S) + 8) tick(1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
